// File: rtl/ec_pkg.sv
// Shared field-arithmetic types, bn128 modulus and stream widths for the EC point units.
package ec_pkg;
    typedef logic [255:0] FE_TYPE;
    typedef logic [63:0]  FE_TYPE_ARITH;

    localparam int FE_BITS          = $bits(FE_TYPE);
    localparam int ARITH_BITS       = $bits(FE_TYPE_ARITH);
    localparam int DIV              = FE_BITS / ARITH_BITS;
    localparam int CNT_BITS         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CTL_BITS_DEFAULT = 8;
    localparam int AXI_IN_DAT_BITS  = 2 * ARITH_BITS;
    localparam int AXI_OUT_DAT_BITS = ARITH_BITS;

    localparam FE_TYPE BN128_P =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    localparam logic [0:0] ST_RX = 1'b0;
    localparam logic [0:0] ST_TX = 1'b1;

    function automatic FE_TYPE_ARITH fe_limb(input FE_TYPE x, input logic [CNT_BITS-1:0] k);
        return x[k*ARITH_BITS +: ARITH_BITS];
    endfunction
endpackage

// File: rtl/ec_limb_addc.sv
// One limb of a ripple add (SUB=0) or subtract (SUB=1); cout is the carry or borrow out.
module ec_limb_addc
    import ec_pkg::*;
#(
    parameter bit SUB = 1'b0
) (
    input  FE_TYPE_ARITH a,
    input  FE_TYPE_ARITH b,
    input  logic         cin,
    output FE_TYPE_ARITH r,
    output logic         cout
);
    logic [ARITH_BITS:0] wide;

    // The extra top bit is the carry for adds and goes high on underflow for subtracts.
    always_comb begin
        if (SUB) begin
            wide = {1'b0, a} - {1'b0, b} - {{ARITH_BITS{1'b0}}, cin};
        end else begin
            wide = {1'b0, a} + {1'b0, b} + {{ARITH_BITS{1'b0}}, cin};
        end
    end

    assign r    = wide[ARITH_BITS-1:0];
    assign cout = wide[ARITH_BITS];
endmodule

// File: rtl/ec_fpn_addsub_stream.sv
// Limb-serial modular add/sub: collects one packet of limbs, picks the raw or P-corrected
// result on the last beat, then streams the result limbs back out.
module ec_fpn_addsub_stream
    import ec_pkg::*;
#(
    parameter FE_TYPE P        = BN128_P,
    parameter bit     SUBTRACT = 1'b0,
    parameter int     CTL_BITS = CTL_BITS_DEFAULT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [AXI_IN_DAT_BITS-1:0]  i_if_dat,
    input  logic                        i_if_val,
    output logic                        i_if_rdy,
    input  logic                        i_if_sop,
    input  logic                        i_if_eop,
    input  logic [CTL_BITS-1:0]         i_if_ctl,
    output logic [AXI_OUT_DAT_BITS-1:0] o_if_dat,
    output logic                        o_if_val,
    input  logic                        o_if_rdy,
    output logic                        o_if_sop,
    output logic                        o_if_eop,
    output logic                        o_if_err,
    output logic [CTL_BITS-1:0]         o_if_ctl
);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(DIV - 1);

    logic [0:0]          state;
    logic [CNT_BITS-1:0] limb_cnt;
    logic [CNT_BITS-1:0] limb_idx;
    logic                chain1, chain2;
    logic                cin1, cin2, cout1, cout2;
    logic                pkt_err, sel_corr, final_sel;
    logic [CTL_BITS-1:0] ctl_q;
    logic                in_fire, out_fire;
    FE_TYPE_ARITH        prim_limb, corr_limb;
    FE_TYPE_ARITH        prim_buf [DIV];
    FE_TYPE_ARITH        corr_buf [DIV];

    assign in_fire  = i_if_val && i_if_rdy;
    assign out_fire = o_if_val && o_if_rdy;

    // A sop beat always restarts at limb 0 with clean chains, even mid-packet.
    assign limb_idx = i_if_sop ? '0 : limb_cnt;
    assign cin1     = !i_if_sop && chain1;
    assign cin2     = !i_if_sop && chain2;

    ec_limb_addc #(.SUB(SUBTRACT)) u_primary (
        .a    (i_if_dat[ARITH_BITS-1:0]),
        .b    (i_if_dat[2*ARITH_BITS-1:ARITH_BITS]),
        .cin  (cin1),
        .r    (prim_limb),
        .cout (cout1)
    );

    ec_limb_addc #(.SUB(!SUBTRACT)) u_correct (
        .a    (prim_limb),
        .b    (fe_limb(P, limb_idx)),
        .cin  (cin2),
        .r    (corr_limb),
        .cout (cout2)
    );

    // add: a+b overflowed or a+b-P did not underflow; sub: a-b underflowed.
    assign final_sel = SUBTRACT ? cout1 : (cout1 | ~cout2);

    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            for (int i = 0; i < DIV; i++) begin
                if (CNT_BITS'(i) == limb_idx) begin
                    prim_buf[i] <= prim_limb;
                    corr_buf[i] <= corr_limb;
                end else if (i_if_eop && (CNT_BITS'(i) > limb_idx)) begin
                    prim_buf[i] <= '0;
                    corr_buf[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_RX;
            limb_cnt <= '0;
            chain1   <= 1'b0;
            chain2   <= 1'b0;
            pkt_err  <= 1'b0;
            sel_corr <= 1'b0;
            ctl_q    <= '0;
            i_if_rdy <= 1'b0;
            o_if_val <= 1'b0;
            o_if_sop <= 1'b0;
            o_if_eop <= 1'b0;
            o_if_err <= 1'b0;
            o_if_dat <= '0;
            o_if_ctl <= '0;
        end else if (state == ST_RX) begin
            i_if_rdy <= 1'b1;
            if (in_fire) begin
                if (i_if_sop) begin
                    ctl_q <= i_if_ctl;
                end
                if ((i_if_sop && (limb_cnt != '0)) || (i_if_eop && (limb_idx != LAST))) begin
                    pkt_err <= 1'b1;
                end
                if (i_if_eop) begin
                    state    <= ST_TX;
                    i_if_rdy <= 1'b0;
                    limb_cnt <= '0;
                    chain1   <= 1'b0;
                    chain2   <= 1'b0;
                    sel_corr <= final_sel;
                end else begin
                    limb_cnt <= limb_idx + 1'b1;
                    chain1   <= cout1;
                    chain2   <= cout2;
                end
            end
        end else begin
            // In TX limb_cnt indexes the next result limb to present.
            if (out_fire && o_if_eop) begin
                state    <= ST_RX;
                i_if_rdy <= 1'b1;
                limb_cnt <= '0;
                pkt_err  <= 1'b0;
                o_if_val <= 1'b0;
                o_if_sop <= 1'b0;
                o_if_eop <= 1'b0;
                o_if_err <= 1'b0;
            end else if (!o_if_val || out_fire) begin
                o_if_val <= 1'b1;
                o_if_dat <= sel_corr ? corr_buf[limb_cnt] : prim_buf[limb_cnt];
                o_if_sop <= (limb_cnt == '0);
                o_if_eop <= (limb_cnt == LAST);
                o_if_err <= pkt_err && (limb_cnt == LAST);
                o_if_ctl <= ctl_q;
                limb_cnt <= limb_cnt + 1'b1;
            end
        end
    end
endmodule
